sipo_deser: RTL and testbench
=============================

# sipo_deser

Serial-in/parallel-out deserializer that sits directly upstream of the team's 4-bit parallel-in/parallel-out register stage. It shifts a qualified serial bit stream into a WIDTH-bit word, LSB first, and presents the completed word on a registered parallel output with a valid/ready handshake. It holds one completed word while the next frame shifts in, and flags overflow when a second word completes before the first is taken.

## Interface
- WIDTH, 4, data bits per frame (≥2)
- clk  input  1  rising-edge clock, single clock domain
- reset  input  1  synchronous, active-high; sampled on rising clk
- serin  input  1  serial data bit
- serin_valid  input  1  serin is sampled on this edge when 1
- frame_start  input  1  with serin_valid, marks serin as bit 0 of a new frame
- dataout  output  WIDTH  completed parallel word (to PIPO datain)
- dataout_valid  output  1  dataout holds an unaccepted word
- dataout_ready  input  1  consumer accepts when valid&ready on an edge
- overflow  output  1  sticky: a completed word was dropped; cleared only by reset
- parity_err  output  1  one-cycle pulse on parity mismatch (tied 0 without macro)

## Operation
- Reset: state IDLE, bit counter 0, shift register 0, dataout 0, dataout_valid 0, overflow 0, parity_err 0.
- States: IDLE (no bits held), SHIFT (1..WIDTH-1 bits held), PAR (data complete, awaiting parity bit; macro only).
- IDLE→SHIFT on any serin_valid; frame_start is implied in IDLE.
- SHIFT: each serin_valid shifts serin into bit position = counter; counter increments. The last data bit (counter = WIDTH-1) completes the frame: go to IDLE, or to PAR with macro.
- frame_start & serin_valid in SHIFT/PAR: partial frame discarded, bit taken as bit 0, counter = 1. No error flag.
- serin_valid = 0: no state change; gaps of any length allowed.
- On completion: if the holding register is empty or being accepted on the same edge, dataout ← word and dataout_valid = 1. Otherwise the word is dropped, overflow ← 1, and dataout is unchanged.
- Accept (valid & ready) without a new completion: dataout_valid ← 0; dataout retains its last value.
- Counter width: $clog2(WIDTH+1). Counter wrap never occurs; it resets on completion.

## Timing
- Word latency: dataout/dataout_valid update on the same edge that samples the last data bit (parity bit with macro). They are visible in the following cycle.
- Minimum frame period: WIDTH cycles (WIDTH+1 with macro). Full throughput is sustained when dataout_ready = 1.
- dataout is stable while dataout_valid = 1 and not accepted.
- Accept and completion on the same edge: new word loaded, dataout_valid stays 1, no overflow.
- Reset mid-frame or mid-hold: all state cleared on that edge. The held word is lost.

## Configuration
- SIPO_PARITY_EN defined: each frame carries WIDTH data bits plus one even-parity bit (XOR of data ^ parity bit = 0). On match the word is delivered as above. On mismatch the word is dropped, dataout_valid is unchanged, and parity_err = 1 for one cycle after the parity edge. Overflow is not set for a parity-failed word.
- Undefined: frames are WIDTH bits, no PAR state, parity_err constant 0.

## Structure
- Package sipo_pkg: state enum (IDLE, SHIFT, PAR) and WIDTH default constant.
- One natural sub-module: sipo_out_reg. It is the output holding register with the valid/ready/overflow logic, fed by a load strobe and word from the shift FSM.

## Test plan
- Reset with serin_valid toggling → dataout = 0, dataout_valid = 0, overflow = 0 throughout reset and the first cycle after.
- WIDTH=4, ready=1, bits 1,1,0,1 on 4 consecutive valid cycles → dataout = 4'b1011, dataout_valid = 1 for exactly one cycle, after the 4th edge.
- Same bits with 1–3 idle cycles between them → identical dataout = 4'b1011 after the 4th valid bit.
- ready=0, frame 4'h5 then frame 4'hA → dataout holds 4'h5, valid = 1, overflow = 1 after 8th bit. Then ready=1 → valid drops, overflow stays 1.
- 2 bits (1,1), then frame_start with bits 0,0,1,0 → single word 4'b0100, no earlier word emitted. Reset after 2 bits of a frame → next 4 bits form a clean word.
- With SIPO_PARITY_EN: data 0,1,1,1 + parity 1 → 4'b1110 delivered. Data 0,1,1,1 + parity 0 → parity_err pulse, no dataout_valid.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and defaults for the serial-in/parallel-out deserializer.
package sipo_pkg;

    localparam int unsigned SIPO_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } sipo_state_e;

endpackage

// File: rtl/sipo_deser_if.sv
// Serial input and parallel output handshake bundle for sipo_deser.
interface sipo_deser_if
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = SIPO_WIDTH
);
    logic             serin;
    logic             serin_valid;
    logic             frame_start;
    logic [WIDTH-1:0] dataout;
    logic             dataout_valid;
    logic             dataout_ready;
    logic             overflow;
    logic             parity_err;

    modport master (
        output serin, serin_valid, frame_start, dataout_ready,
        input  dataout, dataout_valid, overflow, parity_err
    );

    modport slave (
        input  serin, serin_valid, frame_start, dataout_ready,
        output dataout, dataout_valid, overflow, parity_err
    );
endinterface

// File: rtl/sipo_out_reg.sv
// Output holding register: one-word buffer with valid/ready handshake and sticky overflow.
module sipo_out_reg #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] word,
    input  logic             ready,
    output logic [WIDTH-1:0] dataout,
    output logic             dataout_valid,
    output logic             overflow
);
    always_ff @(posedge clk) begin
        if (reset) begin
            dataout       <= '0;
            dataout_valid <= 1'b0;
            overflow      <= 1'b0;
        end else if (load) begin
            // A completion may replace the held word only if that word leaves on this edge.
            if (!dataout_valid || ready) begin
                dataout       <= word;
                dataout_valid <= 1'b1;
            end else begin
                overflow <= 1'b1;
            end
        end else if (dataout_valid && ready) begin
            dataout_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/sipo_deser.sv
// LSB-first serial-to-parallel deserializer feeding the PIPO register stage.
// Optional even-parity bit per frame when SIPO_PARITY_EN is defined.
module sipo_deser
    import sipo_pkg::*;
#(
    parameter int unsigned WIDTH = SIPO_WIDTH
) (
    input logic         clk,
    input logic         reset,
    sipo_deser_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    sipo_state_e      state;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] sreg;
    logic             last_bit;
    logic             load;
    logic [WIDTH-1:0] word;

    assign last_bit = bus.serin_valid && !bus.frame_start && (state == SHIFT) && (cnt == LAST);

`ifdef SIPO_PARITY_EN
    logic par_bit;
    logic par_ok;
    logic par_err;

    assign par_bit = bus.serin_valid && !bus.frame_start && (state == PAR);
    assign par_ok  = ~^{sreg, bus.serin};

    always_comb begin
        load = par_bit && par_ok;
        word = sreg;
    end

    assign bus.parity_err = par_err;
`else
    always_comb begin
        load = last_bit;
        word = {bus.serin, sreg[WIDTH-2:0]};
    end

    assign bus.parity_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            sreg  <= '0;
`ifdef SIPO_PARITY_EN
            par_err <= 1'b0;
`endif
        end else begin
`ifdef SIPO_PARITY_EN
            par_err <= 1'b0;
`endif
            if (bus.serin_valid) begin
                // Any new frame (explicit or implied from IDLE) restarts at bit 0.
                if (state == IDLE || bus.frame_start) begin
                    sreg  <= {{(WIDTH-1){1'b0}}, bus.serin};
                    cnt   <= CNT_W'(1);
                    state <= SHIFT;
                end else if (state == SHIFT) begin
                    sreg <= sreg | (WIDTH'(bus.serin) << cnt);
                    if (last_bit) begin
                        cnt <= '0;
`ifdef SIPO_PARITY_EN
                        state <= PAR;
`else
                        state <= IDLE;
`endif
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end else begin
                    state <= IDLE;
`ifdef SIPO_PARITY_EN
                    par_err <= !par_ok;
`endif
                end
            end
        end
    end

    sipo_out_reg #(
        .WIDTH(WIDTH)
    ) u_out_reg (
        .clk           (clk),
        .reset         (reset),
        .load          (load),
        .word          (word),
        .ready         (bus.dataout_ready),
        .dataout       (bus.dataout),
        .dataout_valid (bus.dataout_valid),
        .overflow      (bus.overflow)
    );
endmodule

// File: tb/tb_sipo_deser.sv
// Self-checking bench for sipo_deser: vector table plus hand-written corner sequences,
// delivered words checked through an expected-word queue.
module tb_sipo_deser;
    localparam int unsigned W = 4;

    logic clk;
    logic reset;

    sipo_deser_if #(.WIDTH(W)) bus ();

    sipo_deser #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned errors = 0;
    int unsigned checks = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] data;
        int unsigned  gap;
        logic [W-1:0] exp;
    } vec_t;

    vec_t tbl[8];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endfunction

    // Every accepted word must match the oldest expected entry.
    always @(negedge clk) begin
        if (!reset && bus.dataout_valid === 1'b1 && bus.dataout_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_word: got %h, required none", bus.dataout);
            end else begin
                check("word", 32'(bus.dataout), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        bus.serin_valid = 1'b0;
        bus.frame_start = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic b, input logic fs);
        bus.serin       = b;
        bus.serin_valid = 1'b1;
        bus.frame_start = fs;
        tick();
        bus.serin_valid = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic send_frame(input logic [W-1:0] data, input int unsigned gap,
                              input logic fs, input logic rdy_last);
        for (int i = 0; i < int'(W); i++) begin
            if (i > 0) idle(gap);
`ifndef SIPO_PARITY_EN
            if (rdy_last && i == int'(W) - 1) bus.dataout_ready = 1'b1;
`endif
            send_bit(data[i], fs && i == 0);
        end
`ifdef SIPO_PARITY_EN
        idle(gap);
        if (rdy_last) bus.dataout_ready = 1'b1;
        send_bit(^data, 1'b0);
`endif
    endtask

    initial begin
        tbl[0] = '{data: 4'b1011, gap: 0, exp: 4'b1011};
        tbl[1] = '{data: 4'b1011, gap: 1, exp: 4'b1011};
        tbl[2] = '{data: 4'b1011, gap: 2, exp: 4'b1011};
        tbl[3] = '{data: 4'b1011, gap: 3, exp: 4'b1011};
        tbl[4] = '{data: 4'h0,    gap: 0, exp: 4'h0};
        tbl[5] = '{data: 4'hF,    gap: 0, exp: 4'hF};
        tbl[6] = '{data: 4'h6,    gap: 2, exp: 4'h6};
        tbl[7] = '{data: 4'h9,    gap: 1, exp: 4'h9};

        reset             = 1'b1;
        bus.serin         = 1'b1;
        bus.serin_valid   = 1'b0;
        bus.frame_start   = 1'b0;
        bus.dataout_ready = 1'b1;

        // Reset held while serial input toggles.
        for (int i = 0; i < 4; i++) begin
            bus.serin_valid = i[0];
            tick();
            check("rst_dataout", 32'(bus.dataout), 32'h0);
            check("rst_valid", 32'(bus.dataout_valid), 32'h0);
            check("rst_overflow", 32'(bus.overflow), 32'h0);
        end
        bus.serin_valid = 1'b0;
        reset = 1'b0;
        tick();
        check("post_rst_valid", 32'(bus.dataout_valid), 32'h0);
        check("post_rst_dataout", 32'(bus.dataout), 32'h0);
        check("post_rst_parity_err", 32'(bus.parity_err), 32'h0);

        // Single frame at full rate: valid for exactly one cycle after the last bit.
        exp_q.push_back(4'b1011);
        send_frame(4'b1011, 0, 1'b0, 1'b0);
        check("one_shot_valid", 32'(bus.dataout_valid), 32'h1);
        check("one_shot_data", 32'(bus.dataout), 32'hB);
        tick();
        check("one_shot_valid_drop", 32'(bus.dataout_valid), 32'h0);
        check("hold_after_accept", 32'(bus.dataout), 32'hB);

        // Table of frames, with and without gaps between bits.
        for (int unsigned k = 0; k < 8; k++) begin
            exp_q.push_back(tbl[k].exp);
            send_frame(tbl[k].data, tbl[k].gap, 1'b0, 1'b0);
            check("tbl_valid", 32'(bus.dataout_valid), 32'h1);
            check("tbl_data", 32'(bus.dataout), 32'(tbl[k].exp));
            check("tbl_parity_err", 32'(bus.parity_err), 32'h0);
            idle(k % 2);
        end
        idle(2);

        // Second completion while the first word is still held.
        bus.dataout_ready = 1'b0;
        send_frame(4'h5, 0, 1'b0, 1'b0);
        send_frame(4'hA, 0, 1'b0, 1'b0);
        check("ovf_data", 32'(bus.dataout), 32'h5);
        check("ovf_valid", 32'(bus.dataout_valid), 32'h1);
        check("ovf_flag", 32'(bus.overflow), 32'h1);
        exp_q.push_back(4'h5);
        bus.dataout_ready = 1'b1;
        tick();
        check("ovf_valid_drop", 32'(bus.dataout_valid), 32'h0);
        check("ovf_sticky", 32'(bus.overflow), 32'h1);

        // Reset in the middle of a frame.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mid_rst_overflow", 32'(bus.overflow), 32'h0);
        check("mid_rst_dataout", 32'(bus.dataout), 32'h0);
        exp_q.push_back(4'h8);
        send_frame(4'h8, 0, 1'b0, 1'b0);
        check("mid_rst_word", 32'(bus.dataout), 32'h8);
        idle(2);

        // frame_start discards a partial frame without emitting it.
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        exp_q.push_back(4'b0100);
        send_frame(4'b0100, 0, 1'b1, 1'b0);
        check("restart_word", 32'(bus.dataout), 32'h4);
        check("restart_valid", 32'(bus.dataout_valid), 32'h1);
        idle(2);
        check("restart_overflow", 32'(bus.overflow), 32'h0);

        // Accept of the held word on the same edge a new word completes.
        bus.dataout_ready = 1'b0;
        exp_q.push_back(4'h3);
        send_frame(4'h3, 0, 1'b0, 1'b0);
        exp_q.push_back(4'hC);
        send_frame(4'hC, 1, 1'b0, 1'b1);
        check("same_edge_data", 32'(bus.dataout), 32'hC);
        check("same_edge_valid", 32'(bus.dataout_valid), 32'h1);
        check("same_edge_overflow", 32'(bus.overflow), 32'h0);
        idle(2);

`ifdef SIPO_PARITY_EN
        exp_q.push_back(4'b1110);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check("par_ok_data", 32'(bus.dataout), 32'hE);
        check("par_ok_valid", 32'(bus.dataout_valid), 32'h1);
        check("par_ok_err", 32'(bus.parity_err), 32'h0);
        idle(2);

        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b0, 1'b0);
        check("par_bad_err", 32'(bus.parity_err), 32'h1);
        check("par_bad_valid", 32'(bus.dataout_valid), 32'h0);
        check("par_bad_overflow", 32'(bus.overflow), 32'h0);
        tick();
        check("par_err_pulse", 32'(bus.parity_err), 32'h0);
`endif

        idle(4);
        check("pending_words", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, required finish");
        $fatal(1);
    end
endmodule
